// File: rtl/hilo_acc.sv
// hilo_acc: HI/LO special registers with joint/partial writes and two-cycle multiply-accumulate/subtract.
module hilo_acc #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   hi_i,
    input  logic [WIDTH-1:0]   lo_i,
    input  logic [2*WIDTH-1:0] prod_i,
    output logic               ready_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               acc_done_o
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t             state, state_n;
    logic [2*WIDTH-1:0] opnd, acc;
    logic               sub, accept, is_acc;
    always_comb begin
        ready_o = state == IDLE;
        accept  = valid_i && ready_o;
        is_acc  = op_i[2:1] == 2'b10;
        state_n = (state == IDLE && accept && is_acc) ? ACC : IDLE;
        acc     = sub ? {hi_o, lo_o} - opnd : {hi_o, lo_o} + opnd;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    // Bits 0/1 of WHI/WLO/WBOTH select which half is written.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hi_o       <= '0;
            lo_o       <= '0;
            opnd       <= '0;
            sub        <= 1'b0;
            acc_done_o <= 1'b0;
        end else begin
            acc_done_o <= state == ACC;
            if (state == ACC) begin
                {hi_o, lo_o} <= acc;
            end else if (accept) begin
                if (!op_i[2] && op_i[0]) hi_o <= hi_i;
                if (!op_i[2] && op_i[1]) lo_o <= lo_i;
                if (is_acc) begin
                    opnd <= prod_i;
                    sub  <= op_i[0];
                end
            end
        end
endmodule

// File: tb/tb_hilo_acc.sv
// tb_hilo_acc: directed and randomized checks of hilo_acc against a 64-bit transaction-level model.
module tb_hilo_acc;
    logic        clk = 0, rst = 1;
    logic        valid = 0;
    logic [2:0]  op = 0;
    logic [31:0] hi_in = 0, lo_in = 0;
    logic [63:0] prod = 0;
    logic        ready, done;
    logic [31:0] hi, lo;
    logic        v16 = 0;
    logic [2:0]  op16 = 0;
    logic [15:0] hi_in16 = 0, lo_in16 = 0;
    logic [31:0] prod16 = 0;
    logic        ready16, done16;
    logic [15:0] hi16, lo16;
    int checks = 0, errors = 0;
    logic [63:0] m_acc, m_opnd;
    bit          m_busy, m_done, m_sub;

    hilo_acc dut (.clk(clk), .rst(rst), .valid_i(valid), .op_i(op), .hi_i(hi_in), .lo_i(lo_in),
                  .prod_i(prod), .ready_o(ready), .hi_o(hi), .lo_o(lo), .acc_done_o(done));
    hilo_acc #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .valid_i(v16), .op_i(op16), .hi_i(hi_in16),
                  .lo_i(lo_in16), .prod_i(prod16), .ready_o(ready16), .hi_o(hi16), .lo_o(lo16),
                  .acc_done_o(done16));

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 0; m_opnd = 0; m_busy = 0; m_done = 0; m_sub = 0;
    endtask

    // One clock: the model applies the architectural rules to the 64-bit {HI,LO} value.
    task automatic step();
        logic       v = valid;
        logic [2:0] o = op;
        logic [31:0] h = hi_in, l = lo_in;
        logic [63:0] p = prod;
        @(posedge clk);
        m_done = m_busy;
        if (m_busy) begin
            m_acc  = m_sub ? m_acc - m_opnd : m_acc + m_opnd;
            m_busy = 0;
        end else if (v) begin
            case (o)
                3'd1: m_acc[63:32] = h;
                3'd2: m_acc[31:0] = l;
                3'd3: m_acc = {h, l};
                3'd4, 3'd5: begin m_busy = 1; m_sub = (o == 3'd5); m_opnd = p; end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] h, input logic [31:0] l, input logic [63:0] p);
        valid = 1; op = o; hi_in = h; lo_in = l; prod = p;
    endtask

    task automatic test_reset();
        drive(3'd3, 32'hDEADBEEF, 32'hDEADBEEF, 0); step(); valid = 0;
        checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL preload_hi: got %h want deadbeef", hi); end
        #2 rst = 1; #1;
        checks++; if (hi !== 0 || lo !== 0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
        checks++; if (ready !== 1 || done !== 0) begin errors++; $display("FAIL reset_flags: ready %b done %b want 1 0", ready, done); end
        rst = 0; model_reset();
    endtask

    task automatic test_partial();
        drive(3'd1, 32'h12345678, 32'h0, 0); step();
        drive(3'd2, 32'h0, 32'h9ABCDEF0, 0); step();
        checks++; if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL partial: got %h/%h want 12345678/9abcdef0", hi, lo); end
        drive(3'd3, 32'h1, 32'h2, 0); step(); valid = 0;
        checks++; if (hi !== 32'h1 || lo !== 32'h2) begin errors++; $display("FAIL wboth: got %h/%h want 1/2", hi, lo); end
    endtask

    task automatic test_madd_carry();
        drive(3'd3, 32'h0, 32'hFFFFFFFF, 0); step();
        drive(3'd4, 0, 0, 64'h1); step(); valid = 0;
        checks++; if (ready !== 0 || done !== 0 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL madd_busy: ready %b done %b lo %h want 0 0 ffffffff", ready, done, lo); end
        step();
        checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL madd_carry: got %h/%h want 1/0", hi, lo); end
        checks++; if (ready !== 1 || done !== 1) begin errors++; $display("FAIL madd_done: ready %b done %b want 1 1", ready, done); end
        step();
        checks++; if (done !== 0) begin errors++; $display("FAIL madd_pulse: done %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        drive(3'd3, 0, 0, 0); step();
        drive(3'd5, 0, 0, 64'h1); step();
        drive(3'd4, 0, 0, 64'h2);
        checks++; if (ready !== 0) begin errors++; $display("FAIL b2b_stall: ready %b want 0", ready); end
        step();
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL msub_wrap: got %h/%h want ffffffff/ffffffff", hi, lo); end
        step(); valid = 0; step();
        checks++; if (hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("FAIL b2b_madd: got %h/%h want 0/1", hi, lo); end
    endtask

    task automatic test_stall();
        drive(3'd3, 0, 0, 0); step();
        drive(3'd4, 0, 0, 64'h5); step();
        drive(3'd3, 32'hAAAA, 32'hBBBB, 0); step();
        checks++; if (hi !== 32'h0 || lo !== 32'h5) begin errors++; $display("FAIL stall_ignore: got %h/%h want 0/5", hi, lo); end
        step(); valid = 0;
        checks++; if (hi !== 32'hAAAA || lo !== 32'hBBBB) begin errors++; $display("FAIL stall_accept: got %h/%h want aaaa/bbbb", hi, lo); end
    endtask

    task automatic test_abort();
        drive(3'd3, 0, 32'hFFFFFFFF, 0); step();
        drive(3'd4, 0, 0, 64'h1); step(); valid = 0;
        #2 rst = 1; #1;
        checks++; if (hi !== 0 || lo !== 0 || ready !== 1) begin errors++; $display("FAIL abort_reset: got %h/%h ready %b want 0/0 1", hi, lo, ready); end
        rst = 0; model_reset(); step();
        checks++; if (done !== 0 || hi !== 0 || lo !== 0) begin errors++; $display("FAIL abort_after: done %b hilo %h/%h want 0 0/0", done, hi, lo); end
    endtask

    task automatic test_width16();
        v16 = 1; op16 = 3'd3; hi_in16 = 16'h0; lo_in16 = 16'hFFFF; step();
        op16 = 3'd4; prod16 = 32'h1; step(); v16 = 0;
        checks++; if (ready16 !== 0) begin errors++; $display("FAIL w16_busy: ready %b want 0", ready16); end
        step();
        checks++; if (hi16 !== 16'h1 || lo16 !== 16'h0 || done16 !== 1) begin errors++; $display("FAIL w16_carry: got %h/%h done %b want 0001/0000 1", hi16, lo16, done16); end
        v16 = 1; step(); v16 = 0;
        #2 rst = 1; #1;
        checks++; if (hi16 !== 0 || lo16 !== 0) begin errors++; $display("FAIL w16_abort: got %h/%h want 0/0", hi16, lo16); end
        rst = 0; model_reset(); step();
        checks++; if (done16 !== 0) begin errors++; $display("FAIL w16_nopulse: done %b want 0", done16); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid = $urandom_range(0, 3) != 0;
            op = 3'($urandom_range(0, 7)); hi_in = $urandom; lo_in = $urandom;
            prod = {$urandom, $urandom};
            checks++; if (ready !== !m_busy) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ready, !m_busy); end
            step();
            checks++; if ({hi, lo} !== m_acc) begin errors++; $display("FAIL rand_hilo[%0d]: got %h want %h", i, {hi, lo}, m_acc); end
            checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done[%0d]: got %b want %b", i, done, m_done); end
        end
        valid = 0;
    endtask

    initial begin
        model_reset();
        #12 rst = 0;
        @(negedge clk);
        test_reset();
        test_partial();
        test_madd_carry();
        test_back_to_back();
        test_stall();
        test_abort();
        test_width16();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
